// File: rtl/bt_tx_arbiter.sv
// bt_tx_arbiter
//   Shares one Bluetooth UART transmitter between N_REQ requesters. A
//   round-robin arbiter grants one requester at a time, latches its byte
//   and runs the enable/busy/done handshake. A watchdog aborts transfers
//   whose transmitter never starts or never finishes, and leaves err set.
//
// Ports
//   clk_in     system clock, rising edge
//   reset      asynchronous active-low reset
//   req        per-requester send request (level, held until ack)
//   req_data   byte for requester i on [8i+7:8i]
//   ack        one-cycle pulse: byte of requester i captured
//   sent       one-cycle pulse: byte of requester i fully transmitted
//   err        sticky abort flag, cleared only by reset
//   owner      index of the last granted requester
//   tx_din     byte to transmitter, held from grant to next grant
//   tx_enable  one-cycle start pulse to transmitter
//   tx_busy    transmitter busy
//   tx_done    transmitter completion pulse
//
// State table
//   S_IDLE      | waiting for a request, arbitrates round-robin
//   S_START     | tx_enable pulse, ack pulse, counter cleared
//   S_WAIT_BUSY | waiting for transmitter to raise busy (or finish fast)
//   S_WAIT_DONE | transmitter busy, waiting for done or busy falling
//   S_DONE      | sent pulse for the owner
//   S_ABORT     | watchdog expired, err set, no sent pulse

module bt_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int START_WAIT  = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     sent,
  output logic                 err,
  output logic [1:0]           owner,
  output logic [7:0]           tx_din,
  output logic                 tx_enable,
  input  logic                 tx_busy,
  input  logic                 tx_done
);

  localparam int LIMIT_MAX = (TIMEOUT_CYC > START_WAIT) ? TIMEOUT_CYC : START_WAIT;
  localparam int CNT_W     = $clog2(LIMIT_MAX + 1);
  // The counter holds the number of cycles already spent in the wait state,
  // so the abort decision is taken when the last allowed cycle is running.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [N_REQ-1:0] ONE        = N_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE,
    S_ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]        owner_q, owner_d;
  logic [7:0]        din_q, din_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  sent_q, sent_d;
  logic              en_q, en_d;
  logic              err_q, err_d;

  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  logic [7:0]        gnt_byte;
  int                cand;

  // Search starts just after the last owner, so the requester served last
  // has the lowest priority.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = owner_q;
    gnt_byte = 8'h00;
    cand     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(owner_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!gnt_vld && ((req & (ONE << cand)) != '0)) begin
        gnt_vld  = 1'b1;
        gnt_idx  = 2'(cand);
        gnt_byte = 8'(req_data >> (8 * cand));
      end
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    din_d   = din_q;
    ack_d   = '0;
    sent_d  = '0;
    en_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          din_d   = gnt_byte;
          owner_d = gnt_idx;
          ack_d   = ONE << gnt_idx;
          en_d    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // done takes priority over busy and over the limit
        if (tx_done) begin
          sent_d  = ONE << owner_q;
          state_d = S_DONE;
        end else if (tx_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q >= START_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        // busy was high on entry, so a low busy here is its falling edge
        if (tx_done || !tx_busy) begin
          sent_d  = ONE << owner_q;
          state_d = S_DONE;
        end else if (cnt_q >= DONE_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 2'(N_REQ - 1);
      din_q   <= 8'h00;
      ack_q   <= '0;
      sent_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      sent_q  <= sent_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  assign ack       = ack_q;
  assign sent      = sent_q;
  assign err       = err_q;
  assign owner     = owner_q;
  assign tx_din    = din_q;
  assign tx_enable = en_q;

endmodule

// File: tb/tb_bt_tx_arbiter.sv
// Directed testbench for bt_tx_arbiter with a small behavioural transmitter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bt_tx_arbiter;

  localparam int N_REQ       = 2;
  localparam int START_WAIT  = 16;
  localparam int TIMEOUT_CYC = 50;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic [1:0]  sent;
  logic        err;
  logic [1:0]  owner;
  logic [7:0]  tx_din;
  logic        tx_enable;
  logic        tx_busy;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int xmit_mode = 0;   // 0 normal, 1 never busy, 2 busy stuck
  int en_cnt   = 0;
  int sent_cnt = 0;

  always #5 clk_in = ~clk_in;

  bt_tx_arbiter #(
    .N_REQ       (N_REQ),
    .START_WAIT  (START_WAIT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .sent      (sent),
    .err       (err),
    .owner     (owner),
    .tx_din    (tx_din),
    .tx_enable (tx_enable),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit cond_hit(input int which);
    case (which)
      0:       return ack != 2'b00;
      1:       return sent != 2'b00;
      default: return err == 1'b1;
    endcase
  endfunction

  // Waits on falling edges until the event appears or the limit expires.
  task automatic wait_for(input int which, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (!cond_hit(which) && cyc < limit);
  endtask

  // Transmitter model: busy two cycles after enable, 20 busy cycles, then
  // done together with busy falling.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk_in);
      if (tx_enable) begin
        if (xmit_mode == 0) begin
          repeat (2) @(negedge clk_in);
          tx_busy = 1'b1;
          repeat (20) @(negedge clk_in);
          tx_busy = 1'b0;
          tx_done = 1'b1;
          @(negedge clk_in);
          tx_done = 1'b0;
        end else if (xmit_mode == 2) begin
          @(negedge clk_in);
          tx_busy = 1'b1;
          repeat (70) @(negedge clk_in);
          tx_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (tx_enable) en_cnt++;
    if (sent != 2'b00) sent_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int s0;
    int e0;
    int bad;
    req      = 2'b00;
    req_data = 16'h0000;
    reset    = 1'b0;
    repeat (3) @(negedge clk_in);

    check_eq("rst_ack",   ack, 0);
    check_eq("rst_sent",  sent, 0);
    check_eq("rst_en",    tx_enable, 0);
    check_eq("rst_err",   err, 0);
    check_eq("rst_din",   tx_din, 8'h00);
    check_eq("rst_owner", owner, 1);
    reset = 1'b1;
    @(negedge clk_in);

    // single request
    req = 2'b01;
    req_data[7:0] = 8'h41;
    wait_for(0, 20, c);
    check_eq("t1_ack_lat", c, 1);
    check_eq("t1_ack",     ack, 2'b01);
    check_eq("t1_en",      tx_enable, 1);
    check_eq("t1_din",     tx_din, 8'h41);
    check_eq("t1_owner",   owner, 0);
    req = 2'b00;
    @(negedge clk_in);
    check_eq("t1_ack_pulse", ack, 0);
    check_eq("t1_en_pulse",  tx_enable, 0);
    wait_for(1, 100, c);
    check_eq("t1_sent_lat", c, 22);
    check_eq("t1_sent",     sent, 2'b01);
    check_eq("t1_err",      err, 0);
    check_eq("t1_din_hold", tx_din, 8'h41);
    @(negedge clk_in);
    check_eq("t1_sent_pulse", sent, 0);
    check_eq("t1_en_cnt",     en_cnt, 1);

    // contention, both requests held
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    req      = 2'b11;
    req_data = 16'h55AA;
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 60, c);
      check_eq("t2_ack_gap", c, (i == 0) ? 32'd1 : 32'd2);
      check_eq("t2_ack",   ack,    (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("t2_owner", owner,  (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq("t2_din",   tx_din, (i % 2 == 0) ? 32'hAA : 32'h55);
      wait_for(1, 100, c);
      check_eq("t2_sent",  sent,   (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i == 3) req = 2'b00;
    end
    repeat (4) @(negedge clk_in);
    check_eq("t2_en_cnt", en_cnt, 5);
    check_eq("t2_err",    err, 0);

    // start timeout: transmitter never raises busy
    xmit_mode = 1;
    s0 = sent_cnt;
    req = 2'b01;
    wait_for(0, 20, c);
    check_eq("t3_ack", ack, 2'b01);
    req = 2'b00;
    wait_for(2, 100, c);
    check_eq("t3_err_lat", 32'((c >= 17) && (c <= 18)), 1);
    check_eq("t3_no_sent", sent_cnt, s0);
    xmit_mode = 0;
    @(negedge clk_in);
    req = 2'b10;
    wait_for(0, 20, c);
    check_eq("t3_next_ack",   ack, 2'b10);
    check_eq("t3_next_owner", owner, 1);
    req = 2'b00;
    wait_for(1, 100, c);
    check_eq("t3_next_sent", sent, 2'b10);
    check_eq("t3_err_stick", err, 1);

    // completion timeout: busy stuck high
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    check_eq("t4_err_clr", err, 0);
    xmit_mode = 2;
    s0 = sent_cnt;
    req = 2'b01;
    wait_for(0, 20, c);
    check_eq("t4_ack", ack, 2'b01);
    req = 2'b00;
    wait_for(2, 200, c);
    check_eq("t4_err_lat", 32'((c >= 52) && (c <= 53)), 1);
    check_eq("t4_no_sent", sent_cnt, s0);
    xmit_mode = 0;
    repeat (25) @(negedge clk_in);
    req = 2'b10;
    wait_for(0, 20, c);
    check_eq("t4_next_ack", ack, 2'b10);
    req = 2'b00;
    wait_for(1, 100, c);
    check_eq("t4_next_sent", sent, 2'b10);
    check_eq("t4_err_stick", err, 1);

    // reset during WAIT_DONE
    @(negedge clk_in);
    req = 2'b01;
    wait_for(0, 20, c);
    check_eq("t5_ack", ack, 2'b01);
    req = 2'b00;
    repeat (8) @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_ack_rst",   ack, 0);
    check_eq("t5_sent_rst",  sent, 0);
    check_eq("t5_en_rst",    tx_enable, 0);
    check_eq("t5_err_rst",   err, 0);
    check_eq("t5_din_rst",   tx_din, 8'h00);
    check_eq("t5_owner_rst", owner, 1);
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    e0 = en_cnt;
    s0 = sent_cnt;
    repeat (20) @(negedge clk_in);
    check_eq("t5_stray_sent", sent_cnt, s0);
    check_eq("t5_stray_en",   en_cnt, e0);
    check_eq("t5_stray_err",  err, 0);
    req = 2'b11;
    wait_for(0, 20, c);
    check_eq("t5_prio0", ack, 2'b01);
    req = 2'b00;
    wait_for(1, 100, c);
    check_eq("t5_sent0", sent, 2'b01);
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    req = 2'b10;
    wait_for(0, 20, c);
    check_eq("t5_prio1", ack, 2'b10);
    req = 2'b00;
    wait_for(1, 100, c);
    check_eq("t5_sent1", sent, 2'b10);

    // data stability after ack
    @(negedge clk_in);
    req = 2'b01;
    req_data[7:0] = 8'h41;
    wait_for(0, 20, c);
    check_eq("t6_ack", ack, 2'b01);
    check_eq("t6_din", tx_din, 8'h41);
    req = 2'b00;
    @(negedge clk_in);
    req_data[7:0] = 8'hFF;
    bad = 0;
    c = 0;
    while (sent == 2'b00 && c < 100) begin
      @(negedge clk_in);
      c++;
      if (tx_din !== 8'h41) bad++;
    end
    check_eq("t6_din_stable", bad, 0);
    check_eq("t6_sent", sent, 2'b01);
    @(negedge clk_in);
    req = 2'b01;
    wait_for(0, 20, c);
    check_eq("t6_new_din", tx_din, 8'hFF);
    req = 2'b00;
    wait_for(1, 100, c);
    check_eq("t6_new_sent", sent, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
